// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame constants and the
// parity function. The transmit side uses the same package so that both
// directions agree on framing and parity.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // The parity bit is good when it equals the XOR of the data bits.
  function automatic logic ps2_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, an
// optional glitch filter on the clock (macro PS2_RX_GLITCH_FILTER_EN), and
// falling-edge detection on the filtered clock level. All flops reset to
// the idle-high line level so that reset never produces a false edge.
module ps2_sync_edge #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic arst,
  input  logic ps2_c,
  input  logic ps2_d,
  output logic fall,
  output logic d_sync
);

  logic c_s1, c_s2, d_s1;
  logic c_filt;
  logic c_prev;

  // A filter length of zero would never accept a level change.
  if (FILTER_LEN < 1) begin : g_bad_len
    $error("ps2_sync_edge: FILTER_LEN must be at least 1");
  end

  // Two-flop synchronizers for both asynchronous lines.
  always_ff @(posedge clk) begin
    if (arst) begin
      c_s1   <= 1'b1;
      c_s2   <= 1'b1;
      d_s1   <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_s1   <= ps2_c;
      c_s2   <= c_s1;
      d_s1   <= ps2_d;
      d_sync <= d_s1;
    end
  end

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] fcnt;

  // Accept a new clock level only after FILTER_LEN consecutive samples
  // disagree with the current filtered level; any agreeing sample restarts.
  always_ff @(posedge clk) begin
    if (arst) begin
      fcnt   <= '0;
      c_filt <= 1'b1;
    end else if (c_s2 == c_filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_LEN - 1)) begin
      fcnt   <= '0;
      c_filt <= c_s2;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end
`else
  assign c_filt = c_s2;
`endif

  // Previous filtered level for the high-to-low edge detector.
  always_ff @(posedge clk) begin
    if (arst) c_prev <= 1'b1;
    else      c_prev <= c_filt;
  end

  assign fall = c_prev & ~c_filt;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver. Frames are start(0), 8 data bits LSB
// first, parity, stop(1), one bit per PS/2 clock falling edge. Result
// pulses (valid / parity_err / frame_err) are registered, so they appear
// the cycle after the deciding edge and are mutually exclusive.
// Optional clock glitch filter: define PS2_RX_GLITCH_FILTER_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 5_000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       PS2_C,
  input  logic       PS2_D,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall, d_bit;

  ps2_sync_edge #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk    (clk),
    .arst   (arst),
    .ps2_c  (PS2_C),
    .ps2_d  (PS2_D),
    .fall   (fall),
    .d_sync (d_bit)
  );

  ps2_state_t          state, state_n;
  logic [2:0]          count, count_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                par_bit, par_n;
  logic [TW-1:0]       timer, timer_n;
  logic [7:0]          data_n;
  logic                valid_n, perr_n, ferr_n;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (arst) begin
      state      <= IDLE;
      count      <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      timer      <= '0;
      data       <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      shift      <= shift_n;
      par_bit    <= par_n;
      timer      <= timer_n;
      data       <= data_n;
      valid      <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
    end
  end

  // Frame FSM: shifts bits on each filtered falling edge, judges the frame
  // at the stop bit, and abandons a frame whose clock stalls too long.
  always_comb begin
    state_n = state;
    count_n = count;
    shift_n = shift;
    par_n   = par_bit;
    timer_n = timer;
    data_n  = data;
    valid_n = 1'b0;
    perr_n  = 1'b0;
    ferr_n  = 1'b0;

    // Timer measures cycles since the last edge, only while mid-frame.
    if (fall)                timer_n = '0;
    else if (state != IDLE)  timer_n = timer + 1'b1;
    else                     timer_n = '0;

    case (state)
      IDLE: begin
        if (fall && d_bit == START_BIT) begin
          state_n = DATA;
          count_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_n[count] = d_bit;
          count_n        = count + 3'd1;
          if (count == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = d_bit;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (d_bit != STOP_BIT)                 ferr_n = 1'b1;
          else if (par_bit != ps2_parity(shift)) perr_n = 1'b1;
          else begin
            data_n  = shift;
            valid_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Stalled clock mid-frame: drop the partial byte and report it.
    if (state != IDLE && !fall && timer == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      count_n = '0;
      shift_n = '0;
      timer_n = '0;
      ferr_n  = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: table of frames with expected outcomes
// pushed to a scoreboard, a monitor that pops on every result pulse, and
// hand-written sequences for timeout, reset mid-frame and clock glitches.
module tb_ps2_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int TO     = 200;
  localparam int FL     = 4;
  localparam int HALF   = CLK_HZ / 20_000;   // half period of a 10 kHz PS/2 clock
`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int LAT = 3 + FL;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0, arst = 1'b1, ps2_c = 1'b1, ps2_d = 1'b1;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy;

  ps2_rx #(.CLK_HZ(CLK_HZ), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk        (clk),
    .arst       (arst),
    .PS2_C      (ps2_c),
    .PS2_D      (ps2_d),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, pe, fe;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       par, stop;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  time  ferr_time = 0, t_last = 0;
  logic busy_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!arst && (valid || parity_err || frame_err)) begin
      if (frame_err) ferr_time = $time;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {61'd0, valid, parity_err, frame_err}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {61'd0, valid, parity_err, frame_err},
            {61'd0, mon_e.v, mon_e.pe, mon_e.fe});
        chk("pulse_data", {56'd0, data}, {56'd0, mon_e.d});
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_d = b;
    repeat (HALF) @(negedge clk);
    ps2_c  = 1'b0;
    t_last = $time;
    repeat (HALF) @(negedge clk);
    ps2_c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    @(negedge clk) ps2_d = 1'b1;
  endtask

  task automatic settle(input string name);
    repeat (20) @(negedge clk);
    chk({name, "_drain"}, 64'(sb.size()), 64'd0);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{8'hA5, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 8'hA5}};
    tbl[1] = '{8'h01, 1'b0, 1'b1, '{1'b0, 1'b1, 1'b0, 8'hA5}};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 8'hA5}};
    tbl[3] = '{8'h3C, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 8'h3C}};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 8'hFF}};
    tbl[5] = '{8'h80, 1'b0, 1'b1, '{1'b0, 1'b1, 1'b0, 8'hFF}};
    tbl[6] = '{8'h80, 1'b1, 1'b1, '{1'b1, 1'b0, 1'b0, 8'h80}};
    tbl[7] = '{8'h00, 1'b1, 1'b1, '{1'b0, 1'b1, 1'b0, 8'h80}};
    tbl[8] = '{8'h00, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 8'h00}};
    tbl[9] = '{8'h7E, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b1, 8'h00}};

    // Reset state.
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("rst_data",  {56'd0, data}, 64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_perr",  {63'd0, parity_err}, 64'd0);
    chk("rst_ferr",  {63'd0, frame_err}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);

    // Table of frames.
    for (int i = 0; i < 10; i++) begin
      sb.push_back(tbl[i].e);
      send_frame(tbl[i].b, tbl[i].par, tbl[i].stop);
      settle("frame");
    end

    // Clock stalls after start + 4 data bits: frame_err TO cycles after the last edge.
    ferr_time = 0;
    sb.push_back('{1'b0, 1'b0, 1'b1, 8'h00});
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk) ps2_d = 1'b1;
    repeat (TO + 40) @(negedge clk);
    chk("timeout_latency", 64'(ferr_time - t_last), 64'((LAT + TO) * 10));
    settle("timeout");

    // Reset pulse during bit 5: frame aborted silently.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    @(negedge clk) ps2_d = 1'b1;
    repeat (10) @(negedge clk);
    arst = 1'b1;
    @(negedge clk) arst = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_data", {56'd0, data}, 64'd0);
    repeat (TO + 40) @(negedge clk);
    settle("midrst");
    sb.push_back('{1'b1, 1'b0, 1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1);
    settle("after_rst");

`ifdef PS2_RX_GLITCH_FILTER_EN
    // Short low glitch on the clock with data low must not start a frame.
    busy_seen = 1'b0;
    @(negedge clk) ps2_d = 1'b0;
    repeat (5) @(negedge clk);
    ps2_c = 1'b0;
    repeat (2) @(negedge clk);
    ps2_c = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    ps2_d = 1'b1;
    chk("glitch_busy", {63'd0, busy_seen}, 64'd0);
    settle("glitch");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency (documentation and derived defaults).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20_000, idle-clock cycles allowed between PS/2 clock falling edges mid-frame.
REQ-003 SHALL have parameter FILTER_LEN, default 4, number of consecutive equal samples required to accept a PS2_C level change.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port arst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port PS2_C, input, 1, asynchronous PS/2 clock line, idle high.
REQ-007 SHALL have port PS2_D, input, 1, asynchronous PS/2 data line, idle high.
REQ-008 SHALL have port data, output, 8, last correctly received byte.
REQ-009 SHALL have port valid, output, 1, one-clk pulse when data is updated.
REQ-010 SHALL have port parity_err, output, 1, one-clk pulse on parity mismatch.
REQ-011 SHALL have port frame_err, output, 1, one-clk pulse on bad stop bit or timeout.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL pass PS2_C and PS2_D each through a 2-flop synchronizer before any use.
REQ-014 SHALL detect a PS2_C falling edge as a filtered-high to filtered-low transition, and SHALL sample the synchronized PS2_D in that same cycle.
REQ-015 SHALL accept the frame format: start bit 0, 8 data bits LSB first, parity bit, stop bit 1, with one bit per falling edge.
REQ-016 SHALL define parity as good when the parity bit equals the XOR-reduction of the 8 data bits (even parity, matching the team's PS/2 transmitter).
REQ-017 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-018 SHALL, in IDLE, on an edge with D=0 go to DATA with the bit counter set to 0; on an edge with D=1 it SHALL ignore the edge and stay in IDLE.
REQ-019 SHALL, in DATA, on each edge store D into shift[count] and increment count; the edge that stores bit 7 SHALL go to PARITY (count is 3 bits and wraps to 0).
REQ-020 SHALL, in PARITY, on an edge capture the parity bit and go to STOP.
REQ-021 SHALL, in STOP, on an edge go to IDLE, and: if D=0, pulse frame_err only; else if parity is bad, pulse parity_err only; else load data and pulse valid.
REQ-022 SHALL make every output pulse the cycle after the stop-bit edge is detected, and SHALL never assert two of valid, parity_err or frame_err in the same cycle.
REQ-023 SHALL clear the timeout counter on every edge; in any state other than IDLE, when the counter reaches TIMEOUT_CYCLES it SHALL pulse frame_err, go to IDLE and discard the partial byte.
REQ-024 SHALL hold data unchanged except on a valid pulse.
REQ-025 SHALL accept back-to-back frames: a start edge detected in the cycle after STOP is left SHALL be accepted.

Reset
REQ-026 SHALL, when arst is high at a rising clk edge, force: state IDLE, count 0, shift 0, timeout 0, data 8'h00, valid/parity_err/frame_err/busy 0, and synchronizer/filter flops 1 (idle-high).
REQ-027 SHALL, on reset mid-frame, abort the frame without any error pulse; the first frame whose start edge comes after arst deasserts SHALL be received normally.

Configuration
REQ-028 SHALL, with macro PS2_RX_GLITCH_FILTER_EN defined, apply the FILTER_LEN-sample filter to synchronized PS2_C, adding FILTER_LEN cycles of edge latency.
REQ-029 SHALL, without PS2_RX_GLITCH_FILTER_EN, use the synchronized PS2_C directly as the filtered level, and SHALL ignore FILTER_LEN.

Structure
REQ-030 SHALL place the state encoding (IDLE/DATA/PARITY/STOP), the frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8) and the parity function in shared package ps2_pkg, which PS/2 transmit-side code also uses.
REQ-031 SHALL put the synchronizers, the optional filter and the falling-edge detect in a single sub-module, ps2_sync_edge.

Verification
REQ-032 Bench SHALL cover: frame 0xA5 with parity 0 and stop 1 at a 10 kHz PS/2 clock -> one valid pulse, data=8'hA5, no error pulses.
REQ-033 Bench SHALL cover: frame 0x01 with parity bit 0 -> one parity_err pulse, no valid pulse, data keeps its previous value.
REQ-034 Bench SHALL cover: frame 0x3C with stop bit 0 -> one frame_err pulse, then the next frame 0x3C with stop bit 1 -> valid pulse with data=8'h3C.
REQ-035 Bench SHALL cover: PS2_C held high after 4 data bits -> frame_err pulse exactly TIMEOUT_CYCLES cycles after the last edge, then busy=0.
REQ-036 Bench SHALL cover: arst asserted for 1 cycle during bit 5 -> no pulses and busy=0; the following frame 0x5A -> data=8'h5A.
REQ-037 Bench SHALL cover, with PS2_RX_GLITCH_FILTER_EN defined: a 2-cycle low glitch on PS2_C in IDLE with PS2_D=0 -> no state change and busy stays 0.
